// File: rtl/pattern_count_engine.sv
// pattern_count_engine: streams a message byte-wise and counts in-byte, per-byte and cross-byte pattern hits
module pattern_count_engine #(
  parameter int PAT_W  = 5,
  parameter int NBYTES = 32,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [PAT_W-1:0] pat_mask,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_within,
  output logic [CNT_W-1:0] cnt_bytes,
  output logic [CNT_W-1:0] cnt_cross
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state;
  logic [PAT_W-1:0] pat_q, mask_q;
  logic [7:0]       byte_idx;
  logic [6:0]       hist;
  logic [14:0]      cat;
  logic [3:0]       inc_w, inc_c;
  function automatic logic hit(input logic [PAT_W-1:0] w);
    return ((w ^ pat_q) & mask_q) == '0;
  endfunction
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W+3:0] s;
    s = (CNT_W+4)'(a) + (CNT_W+4)'(b);
    return (s > (CNT_W+4)'({CNT_W{1'b1}})) ? '1 : s[CNT_W-1:0];
  endfunction
  assign cat = {hist, byte_data};
  // on the first byte a cross window is valid only once PAT_W bits have arrived
  always_comb begin
    inc_w = '0;
    inc_c = '0;
    for (int k = 0; k <= 8 - PAT_W; k++)
      inc_w = inc_w + 4'(hit(PAT_W'(byte_data >> k)));
    for (int i = 0; i < 8; i++)
      inc_c = inc_c + 4'(hit(PAT_W'(cat >> i)) && (byte_idx != '0 || i <= 8 - PAT_W));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cnt_within <= '0;
      cnt_bytes  <= '0;
      cnt_cross  <= '0;
      byte_idx   <= '0;
      hist       <= '0;
      pat_q      <= '0;
      mask_q     <= '0;
    end else if (state == RUN) begin
      if (byte_valid) begin
        cnt_within <= sat(cnt_within, inc_w);
        cnt_bytes  <= sat(cnt_bytes, 4'(inc_w != '0));
        cnt_cross  <= sat(cnt_cross, inc_c);
        hist       <= byte_data[6:0];
        byte_idx   <= byte_idx + 8'd1;
        if (byte_idx == 8'(NBYTES - 1)) begin
          state      <= DONE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
      end
    end else if (start) begin
      state      <= RUN;
      byte_ready <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      cnt_within <= '0;
      cnt_bytes  <= '0;
      cnt_cross  <= '0;
      byte_idx   <= '0;
      hist       <= '0;
      pat_q      <= pat;
      mask_q     <= pat_mask;
    end
  end
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: scoreboard bench for pattern_count_engine (default counters and a 6-bit saturating copy)
module tb_pattern_count_engine;
  localparam int PW = 5;
  localparam int NB = 32;
  typedef struct {
    string name;
    int    st;
    int    w;
    int    b;
    int    c;
  } exp_t;
  logic       clk = 0, reset = 0, start = 0, byte_valid = 0;
  logic [4:0] pat = 0, pat_mask = 0;
  logic [7:0] byte_data = 0;
  logic       byte_ready, busy, done, byte_ready6, busy6, done6;
  logic [7:0] cnt_within, cnt_bytes, cnt_cross;
  logic [5:0] w6, b6, c6;
  exp_t       q[$];
  exp_t       e;
  logic [7:0] msg[NB];
  int         total = 0, bad = 0, cyc = 0;
  logic       snap_req = 0, fin = 0, done_d = 0, last_xfer = 0;
  always #5 clk = ~clk;
  pattern_count_engine #(.PAT_W(PW), .NBYTES(NB), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .pat(pat), .pat_mask(pat_mask),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .busy(busy), .done(done), .cnt_within(cnt_within), .cnt_bytes(cnt_bytes), .cnt_cross(cnt_cross));
  pattern_count_engine #(.PAT_W(PW), .NBYTES(NB), .CNT_W(6)) dut6 (
    .clk(clk), .reset(reset), .start(start), .pat(pat), .pat_mask(pat_mask),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready6),
    .busy(busy6), .done(done6), .cnt_within(w6), .cnt_bytes(b6), .cnt_cross(c6));
  function automatic int sat6(input int v);
    return v > 63 ? 63 : v;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(posedge clk) last_xfer <= byte_valid && byte_ready;
  // monitor: pops one expectation whenever done rises or a snapshot is requested
  always @(negedge clk) begin
    cyc++;
    if ((done && !done_d) || snap_req) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got done=%0d with empty scoreboard", done);
      end else begin
        e = q.pop_front();
        chk({e.name, ".status"}, int'({done, busy, byte_ready}), e.st);
        chk({e.name, ".within"}, int'(cnt_within), e.w);
        chk({e.name, ".bytes"}, int'(cnt_bytes), e.b);
        chk({e.name, ".cross"}, int'(cnt_cross), e.c);
        chk({e.name, ".status6"}, int'({done6, busy6, byte_ready6}), e.st);
        chk({e.name, ".within6"}, int'(w6), sat6(e.w));
        chk({e.name, ".bytes6"}, int'(b6), sat6(e.b));
        chk({e.name, ".cross6"}, int'(c6), sat6(e.c));
        if (!snap_req) chk({e.name, ".done_lat"}, int'(last_xfer), 1);
      end
    end
    done_d = done;
    if (fin || cyc > 60000) begin
      if (!fin) begin
        bad++;
        $display("FAIL watchdog: got cycle %0d expected finish before 60000", cyc);
      end
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL %s.missing: got no done expected done", e.name);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end
  task automatic fill(input int mode, input logic [7:0] v);
    for (int j = 0; j < NB; j++) msg[j] = mode == 0 ? v : 8'($urandom);
  endtask
  task automatic model(input logic [4:0] p, input logic [4:0] m, output int w, output int b, output int c);
    logic [8*NB-1:0] bits;
    logic [4:0] win;
    bit any;
    w = 0;
    b = 0;
    c = 0;
    for (int j = 0; j < NB; j++) begin
      any = 0;
      for (int k = 0; k <= 8 - PW; k++) begin
        win = 5'(msg[j] >> k);
        if (((win ^ p) & m) == 0) begin
          w++;
          any = 1;
        end
      end
      if (any) b++;
      for (int t = 0; t < 8; t++) bits[8*j+t] = msg[j][7-t];
    end
    for (int s = 0; s <= 8*NB - PW; s++) begin
      win = 0;
      for (int t = 0; t < PW; t++) win = {win[3:0], bits[s+t]};
      if (((win ^ p) & m) == 0) c++;
    end
  endtask
  task automatic run(input logic [4:0] p, input logic [4:0] m, input bit gaps, input int nx);
    @(posedge clk); #1;
    pat = p;
    pat_mask = m;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int j = 0; j < nx; j++) begin
      if (gaps)
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          byte_valid = 0;
          start = 1'($urandom_range(1, 0));
          @(posedge clk); #1;
        end
      start = 0;
      byte_valid = 1;
      byte_data = msg[j];
      @(posedge clk); #1;
    end
    byte_valid = 0;
    if (nx == NB)
      for (int t = 0; t < 20 && !done; t++) @(posedge clk);
  endtask
  task automatic snap_zero(input string n);
    q.push_back('{n, 0, 0, 0, 0});
    snap_req = 1;
    @(negedge clk); #1;
    snap_req = 0;
  endtask
  initial begin
    int w, b, c;
    logic [4:0] p, m;
    #12;
    snap_zero("reset");
    reset = 1;
    fill(0, 8'h00);
    q.push_back('{"zeros", 4, 128, 32, 252});
    run(5'b00000, 5'b11111, 0, NB);
    fill(0, 8'h55);
    q.push_back('{"alt", 4, 64, 32, 126});
    run(5'b10101, 5'b11111, 0, NB);
    fill(1, 8'h00);
    q.push_back('{"nomask", 4, 128, 32, 252});
    run(5'($urandom), 5'b00000, 0, NB);
    fill(0, 8'h00);
    q.push_back('{"nomatch", 4, 0, 0, 0});
    run(5'b11111, 5'b11111, 0, NB);
    for (int r = 0; r < 3; r++) begin
      fill(1, 8'h00);
      p = 5'($urandom);
      m = 5'($urandom);
      model(p, m, w, b, c);
      q.push_back('{$sformatf("rand%0d", r), 4, w, b, c});
      run(p, m, 1, NB);
    end
    fill(0, 8'h00);
    run(5'b00000, 5'b11111, 0, 10);
    #1 reset = 0;
    snap_zero("midreset");
    reset = 1;
    q.push_back('{"after_reset", 4, 128, 32, 252});
    run(5'b00000, 5'b11111, 0, NB);
    fill(0, 8'h55);
    q.push_back('{"restart", 4, 64, 32, 126});
    run(5'b10101, 5'b11111, 0, NB);
    repeat (2) @(posedge clk);
    fin = 1;
  end
endmodule

// File: doc/pattern_count_engine.md
Name: pattern_count_engine

Overview:
- Streaming hardware successor to the program-3 software pattern search.
- Accepts a NBYTES-byte message one byte per handshake and a PAT_W-bit pattern with a per-bit compare mask.
- Produces the same three counts program 3 writes to data memory 33/34/35:
  - patterns fully inside a byte;
  - bytes containing at least one pattern;
  - patterns anywhere in the bitstream, crossing byte boundaries.
- Sits beside the data memory; a controller or bench streams memory[0..NBYTES-1] in and stores the results.

Parameters:
PAT_W, 5, pattern width in bits; legal 1..8
NBYTES, 32, bytes per message; legal 1..255
CNT_W, 8, width of each result counter; counters saturate

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  begin new search; sampled only in IDLE or DONE
pat  in  PAT_W  pattern; captured on accepted start
pat_mask  in  PAT_W  1 = compare bit, 0 = don't-care; captured with pat
byte_valid  in  1  byte_data valid
byte_data  in  8  message byte; byte 0 first; bit 7 is earliest in bitstream
byte_ready  out  1  engine accepts a byte this cycle
busy  out  1  high in RUN
done  out  1  high in DONE (level)
cnt_within  out  CNT_W  patterns with no byte crossing
cnt_bytes  out  CNT_W  bytes with at least one in-byte pattern
cnt_cross  out  CNT_W  patterns over the whole bitstream

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; byte_ready=0, busy=0, done=0;
  - all counts 0; byte counter 0; bit-history register 0; captured pat/mask 0.
- Match definition: window w matches when (w ^ pat_q) & mask_q == 0.
- FSM states:
  - IDLE: start=1 captures pat/mask, clears counts, byte index and history -> RUN.
  - RUN: byte_ready=1, busy=1. Each byte_valid & byte_ready cycle is one transfer. After transfer NBYTES -> DONE. byte_valid=0 stalls with no state change. start is ignored.
  - DONE: done=1, byte_ready=0. Counts hold stable. start=1 behaves as in IDLE (restart, done drops next cycle).
- Per accepted byte b:
  - In-byte windows are b[k+PAT_W-1:k] for k = 0..8-PAT_W.
  - cnt_within += number of matching in-byte windows.
  - cnt_bytes += 1 if any in-byte window matches.
  - Cross windows: keep the last PAT_W-1 stream bits in a history register and form the (PAT_W-1+8)-bit concatenation {history, b}.
  - Count the 8 windows ending at each bit of b. A window counts only if its first bit is at absolute stream position >= 0, i.e. only if at least PAT_W bits have been seen, including the current bit.
  - History <= low PAT_W-1 bits of the concatenation.
  - Total cross windows = 8*NBYTES-PAT_W+1 (252 for the defaults).
- All increments for a byte apply in the same cycle as the transfer. The counts for the final byte are visible on the cycle done rises, one clock after the last transfer.
- Arithmetic:
  - Per-byte increments are at most 8.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- PAT_W=8: in-byte windows = 1; PAT_W=1: 8 in-byte windows.
- Reset mid-RUN returns to IDLE immediately; partial counts are discarded (zeroed).

Test Plan:
- Defaults, pat=0, mask=11111, 32 bytes of 0x00 -> cnt_within=128, cnt_bytes=32, cnt_cross=252, done high one cycle after 32nd transfer.
- pat=10101, mask=11111, 32 bytes of 0x55 -> cnt_within=64, cnt_bytes=32, cnt_cross=126.
- mask=00000, any pat, random bytes -> 128/32/252. Also pat=11111 on all 0x00 -> 0/0/0.
- CNT_W=6, pat=0, all-zero bytes -> cnt_within=63, cnt_bytes=32, cnt_cross=63 (saturated, no wrap).
- Random byte_valid gaps (≈50% duty) with random data and pattern -> counts equal a bench reference model with the program-3 formulas; start pulsed during RUN is ignored.
- Drive reset low after 10 transfers -> outputs 0 asynchronously, state IDLE. New start with 0x00 stream and pat=0 -> 128/32/252. Restart from DONE clears the previous counts.
